instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage directly upstream of the immediate sign extender and decoder. Keeps the PC and
//  issues word fetches to instruction memory over a req/ack handshake. Buffers returned words
//  in a DEPTH-entry FIFO. Presents the head entry as Instr_Rd (with its PC) to decode under
//  valid/ready, and flushes on a taken branch/jump redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset release
//  DEPTH     2              instruction buffer entries (power of 2, >=2)
//  NOP_INSTR 32'h0000_0013  value driven on Instr_Rd while the buffer is empty (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  PCSrc        in   1   redirect strobe (taken branch/jump), single-cycle pulse
//  PCTarget     in   32  redirect target, sampled when PCSrc=1
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address, word aligned
//  imem_ack     in   1   memory accepts request; imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  Instr_Rd     out  32  head instruction to decode/extender
//  PC_out       out  32  PC of Instr_Rd
//  PCPlus4_out  out  32  PC_out + 4 (mod 2^32)
//  instr_valid  out  1   Instr_Rd/PC_out valid
//  instr_ready  in   1   decode consumes head when instr_valid & instr_ready
// BEHAVIOUR
//  Reset (async assert, sync deassert by system):
//   fetch_pc=RESET_PC; FIFO empty; state=FETCH; imem_req=0; instr_valid=0; Instr_Rd=NOP_INSTR;
//   PC_out=0; PCPlus4_out=4.
//  imem_req is registered. It rises on the first clk edge after rst_n release.
//  FSM: FETCH  imem_req=1, imem_addr=fetch_pc. Held stable until imem_ack.
//         ack & no redirect: push {fetch_pc,imem_rdata}; fetch_pc+=4.
//         Next state FULL if the push leaves no free entry (after this cycle's pop).
//       FULL   imem_req=0. Returns to FETCH the cycle after a pop frees an entry.
//  Single outstanding request. A request is issued only while count<DEPTH, so every ack has a
//   free slot. No overflow is possible.
//  imem_ack while imem_req=0 is ignored.
//  Pop: instr_valid & instr_ready -> head advances next edge. Push and pop in the same cycle
//   leave count unchanged.
//  Redirect (PCSrc=1), highest priority:
//   - flush FIFO (count=0); fetch_pc=PCTarget & ~32'h3; state=FETCH
//   - an ack in the same cycle is dropped (data not pushed)
//   - a pending unacked request is withdrawn: next cycle imem_req=1 with imem_addr=new target
//   - simultaneous pop is ignored
//   - instr_valid=0 the cycle after redirect; earliest valid is 1 cycle after ack of target
//  Latency: ack at edge N -> instr_valid=1, Instr_Rd=data after edge N (zero-bubble).
//   Sustained 1 instr/clk when ack is constant 1 and ready is constant 1.
//  Empty: instr_valid=0; Instr_Rd=NOP_INSTR; PC_out/PCPlus4_out hold their last values.
//  Pointers wrap modulo DEPTH. fetch_pc wraps 32'hFFFF_FFFC -> 0 with no error.
//  Reset mid-transaction: all state cleared immediately. Memory must tolerate the withdrawn req.
// TESTING
//  1 Reset release, ack=1, ready=1: imem_addr 0,4,8 on successive cycles.
//    Instr_Rd follows rdata one cycle later, PC_out=0,4,8, PCPlus4_out=4,8,12.
//  2 ready=0, ack=1: two words buffered (DEPTH=2), imem_req drops to 0.
//    ready=1 for 1 cycle -> head=word0, then imem_req=1 with addr 8 the next cycle.
//  3 ack delayed 3 cycles: imem_addr holds 0 and imem_req stays 1 until ack.
//    instr_valid=0 throughout, Instr_Rd=32'h0000_0013.
//  4 PCSrc=1, PCTarget=32'h0000_0102 with 2 entries buffered and ack in the same cycle:
//    ack data dropped, instr_valid=0 next cycle, imem_addr=32'h0000_0100.
//  5 Assert rst_n=0 asynchronously mid-wait (req=1): imem_req and instr_valid go 0 immediately.
//    After release, refetch starts at RESET_PC.
//  6 fetch_pc=32'hFFFF_FFFC, ack: next imem_addr=0, PCPlus4_out=0 for that entry.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem req/ack fetch, DEPTH-entry
// instruction buffer presented to decode under valid/ready, flushed on redirect.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_Rd,
    output logic [31:0] PC_out,
    output logic [31:0] PCPlus4_out,
    output logic        instr_valid,
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {FETCH, FULL} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     last_pc_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            push, pop;

    // A redirect cancels both the same-cycle ack and the same-cycle pop.
    assign push = req_q & imem_ack & ~PCSrc;
    assign pop  = instr_valid & instr_ready & ~PCSrc;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (PCSrc) begin
            state_d    = FETCH;
            req_d      = 1'b1;
            fetch_pc_d = PCTarget & ~32'h3;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                FETCH:   if (push && count_d == CW'(DEPTH)) state_d = FULL;
                FULL:    if (pop) state_d = FETCH;
                default: state_d = FETCH;
            endcase
            // Registered request: only asked for while a slot is guaranteed free.
            req_d = (state_d == FETCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC & ~32'h3;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (instr_valid)
                last_pc_q <= pc_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign Instr_Rd    = instr_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;
    // PC outputs hold the last presented value while the buffer is empty.
    assign PC_out      = instr_valid ? pc_mem[rd_ptr_q] : last_pc_q;
    assign PCPlus4_out = PC_out + 32'd4;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: memory returns addr ^ 32'hA5A5_0000.
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_Rd;
    logic [31:0] PC_out;
    logic [31:0] PCPlus4_out;
    logic        instr_valid;
    logic        instr_ready;

    int vecs = 0;
    int errs = 0;

    instr_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .Instr_Rd(Instr_Rd), .PC_out(PC_out),
        .PCPlus4_out(PCPlus4_out), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; imem_ack = 1'b0; instr_ready = 1'b0;
        #12;
        check("rst_req",    {31'd0, imem_req},    32'd0);
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_instr",  Instr_Rd,             32'h0000_0013);
        check("rst_pc",     PC_out,               32'h0);
        check("rst_pc4",    PCPlus4_out,          32'h4);

        // Streaming with ack=1, ready=1
        rst_n = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
        tick();
        check("t1_req",     {31'd0, imem_req},    32'd1);
        check("t1_addr0",   imem_addr,            32'h0);
        check("t1_v0",      {31'd0, instr_valid}, 32'd0);
        tick();
        check("t1_addr4",   imem_addr,            32'h4);
        check("t1_instr0",  Instr_Rd,             32'hA5A5_0000);
        check("t1_pc0",     PC_out,               32'h0);
        check("t1_pc4_0",   PCPlus4_out,          32'h4);
        tick();
        check("t1_addr8",   imem_addr,            32'h8);
        check("t1_instr4",  Instr_Rd,             32'hA5A5_0004);
        check("t1_pc4",     PC_out,               32'h4);
        check("t1_pc4_4",   PCPlus4_out,          32'h8);
        tick();
        check("t1_addr12",  imem_addr,            32'hC);
        check("t1_instr8",  Instr_Rd,             32'hA5A5_0008);
        check("t1_pc8",     PC_out,               32'h8);
        check("t1_pc4_8",   PCPlus4_out,          32'hC);

        // Backpressure fills the buffer and drops the request
        instr_ready = 1'b0;
        tick();
        check("t2_req_drop", {31'd0, imem_req},    32'd0);
        check("t2_head",     Instr_Rd,             32'hA5A5_0008);
        tick();
        check("t2_req_hold", {31'd0, imem_req},    32'd0);
        check("t2_pc_hold",  PC_out,               32'h8);
        check("t2_valid",    {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        tick();
        check("t2_req_back", {31'd0, imem_req},    32'd1);
        check("t2_addr16",   imem_addr,            32'h10);
        check("t2_head12",   Instr_Rd,             32'hA5A5_000C);
        check("t2_pc12",     PC_out,               32'hC);

        // Redirect with an entry buffered and an ack in the same cycle
        PCSrc = 1'b1; PCTarget = 32'h0000_0102; imem_ack = 1'b1; instr_ready = 1'b0;
        tick();
        PCSrc = 1'b0; imem_ack = 1'b0;
        check("t4_valid",   {31'd0, instr_valid}, 32'd0);
        check("t4_addr",    imem_addr,            32'h100);
        check("t4_req",     {31'd0, imem_req},    32'd1);
        check("t4_nop",     Instr_Rd,             32'h0000_0013);
        check("t4_pc_hold", PC_out,               32'hC);
        check("t4_pc4_hold",PCPlus4_out,          32'h10);

        // Ack withheld for 3 cycles: request and address held, nothing valid
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_req",   {31'd0, imem_req},    32'd1);
            check("t3_addr",  imem_addr,            32'h100);
            check("t3_valid", {31'd0, instr_valid}, 32'd0);
            check("t3_nop",   Instr_Rd,             32'h0000_0013);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("t3_instr",   Instr_Rd,             32'hA5A5_0100);
        check("t3_pc",      PC_out,               32'h100);
        check("t3_next",    imem_addr,            32'h104);

        // Asynchronous reset while a request is pending
        #4;
        rst_n = 1'b0;
        #1;
        check("t5_req",     {31'd0, imem_req},    32'd0);
        check("t5_valid",   {31'd0, instr_valid}, 32'd0);
        check("t5_nop",     Instr_Rd,             32'h0000_0013);
        check("t5_pc",      PC_out,               32'h0);
        rst_n = 1'b1;
        tick();
        check("t5_refetch", imem_addr,            32'h0);
        check("t5_req_up",  {31'd0, imem_req},    32'd1);

        // Fetch PC wrap at the top of the address space
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFF; instr_ready = 1'b1;
        tick();
        PCSrc = 1'b0;
        check("t6_addr_top", imem_addr,           32'hFFFF_FFFC);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("t6_addr_wrap", imem_addr,          32'h0);
        check("t6_pc",        PC_out,             32'hFFFF_FFFC);
        check("t6_pc4",       PCPlus4_out,        32'h0);
        check("t6_instr",     Instr_Rd,           32'h5A5A_FFFC);
        tick();
        check("t6_empty",    {31'd0, instr_valid}, 32'd0);
        check("t6_pc_hold",  PC_out,               32'hFFFF_FFFC);
        check("t6_pc4_hold", PCPlus4_out,          32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
